tjmono2_rx_eye_scan: RTL and testbench

- Calibration sequencer for the TJ-Monopix2 serial receiver. Runs in the BUS_CLK domain and drives the receiver's data-delay tap (5 bits) and sampling-edge select.
- Sweeps every (edge, tap) setting. For each setting it resets the receiver, waits for sync lock, then counts 8b10b decoder errors over a test window.
- Finds the longest contiguous run of error-free taps and leaves the receiver configured at the centre of that run.
- Sits between the register/bus layer and the receiver core. Its CONF outputs replace the static register values while a calibration is active or has completed.

---
 rtl/tjmono2_rx_eye_scan.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tjmono2_rx_eye_scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tjmono2_rx_eye_scan.sv
// Eye-scan calibration sequencer for the TJ-Monopix2 receiver: sweeps every (edge, tap) setting
// and parks the receiver at the centre of the widest error-free run. Optional map: TJMONO2_EYE_SCAN_MAP_EN.
module tjmono2_rx_eye_scan #(
  parameter int SETTLE_CYCLES = 64,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int TEST_CYCLES   = 65536,
  parameter int CNT_W         = 17
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        START,
  input  logic        RX_READY,
  input  logic        DECODER_ERR,
  output logic        RX_RST,
  output logic [4:0]  CONF_RX_DATA_DLY,
  output logic        CONF_SAMPLING_EDGE,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [4:0]  BEST_DLY,
  output logic        BEST_EDGE,
  output logic [5:0]  EYE_WIDTH
`ifdef TJMONO2_EYE_SCAN_MAP_EN
  , output logic [63:0] EYE_MAP
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_APPLY, ST_SETTLE, ST_LOCK, ST_TEST, ST_EVAL, ST_FINAL, ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TEST_LAST   = CNT_W'(TEST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_q, edge_d;
  logic [4:0]       tap_q, tap_d;
  logic             tap_fail_q, tap_fail_d;
  logic [4:0]       cur_start_q, cur_start_d;
  logic [5:0]       cur_len_q, cur_len_d;
  logic [4:0]       run_start_q, run_start_d;
  logic [5:0]       run_len_q, run_len_d;
  logic             run_edge_q, run_edge_d;
  logic             rx_rst_q, rx_rst_d;
  logic [4:0]       conf_dly_q, conf_dly_d;
  logic             conf_edge_q, conf_edge_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [4:0]       best_dly_q, best_dly_d;
  logic             best_edge_q, best_edge_d;
  logic [5:0]       eye_width_q, eye_width_d;
  logic [5:0]       new_len_s;
  logic [4:0]       new_start_s;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
  logic [63:0]      eye_map_q, eye_map_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    tap_d       = tap_q;
    tap_fail_d  = tap_fail_q;
    cur_start_d = cur_start_q;
    cur_len_d   = cur_len_q;
    run_start_d = run_start_q;
    run_len_d   = run_len_q;
    run_edge_d  = run_edge_q;
    rx_rst_d    = 1'b0;
    conf_dly_d  = conf_dly_q;
    conf_edge_d = conf_edge_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    best_dly_d  = best_dly_q;
    best_edge_d = best_edge_q;
    eye_width_d = eye_width_q;
    new_len_s   = cur_len_q + 6'd1;
    new_start_s = (cur_len_q == 6'd0) ? tap_q : cur_start_q;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
    eye_map_d   = eye_map_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d     = ST_APPLY;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          edge_d      = 1'b0;
          tap_d       = 5'd0;
          cur_start_d = 5'd0;
          cur_len_d   = 6'd0;
          run_start_d = 5'd0;
          run_len_d   = 6'd0;
          run_edge_d  = 1'b0;
          rx_rst_d    = 1'b1;
          conf_dly_d  = 5'd0;
          conf_edge_d = 1'b0;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
          eye_map_d   = 64'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOCK: begin
        if (RX_READY) begin
          state_d    = ST_TEST;
          cnt_d      = '0;
          tap_fail_d = 1'b0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d    = ST_EVAL;
          tap_fail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TEST: begin
        // Losing lock fails the tap and abandons the rest of the window.
        if (DECODER_ERR || !RX_READY) begin
          tap_fail_d = 1'b1;
        end else begin
          tap_fail_d = tap_fail_q;
        end
        if (!RX_READY || cnt_q == TEST_LAST) begin
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        if (!tap_fail_q) begin
          cur_len_d   = new_len_s;
          cur_start_d = new_start_s;
          if (new_len_s > run_len_q) begin
            run_len_d   = new_len_s;
            run_start_d = new_start_s;
            run_edge_d  = edge_q;
          end else begin
            run_len_d = run_len_q;
          end
        end else begin
          cur_len_d = 6'd0;
        end
`ifdef TJMONO2_EYE_SCAN_MAP_EN
        eye_map_d[{edge_q, tap_q}] = ~tap_fail_q;
`endif
        if (tap_q != 5'd31) begin
          state_d     = ST_APPLY;
          tap_d       = tap_q + 5'd1;
          rx_rst_d    = 1'b1;
          conf_dly_d  = tap_q + 5'd1;
          conf_edge_d = edge_q;
        end else if (!edge_q) begin
          // Runs never span the two sampling edges.
          state_d     = ST_APPLY;
          edge_d      = 1'b1;
          tap_d       = 5'd0;
          cur_len_d   = 6'd0;
          rx_rst_d    = 1'b1;
          conf_dly_d  = 5'd0;
          conf_edge_d = 1'b1;
        end else begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        state_d  = ST_DONE;
        rx_rst_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        if (run_len_q != 6'd0) begin
          best_dly_d  = run_start_q + 5'((run_len_q - 6'd1) >> 1);
          best_edge_d = run_edge_q;
          eye_width_d = run_len_q;
          fail_d      = 1'b0;
        end else begin
          best_dly_d  = 5'd2;
          best_edge_d = 1'b1;
          eye_width_d = 6'd0;
          fail_d      = 1'b1;
        end
        conf_dly_d  = (run_len_q != 6'd0) ? run_start_q + 5'((run_len_q - 6'd1) >> 1) : 5'd2;
        conf_edge_d = (run_len_q != 6'd0) ? run_edge_q : 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_q      <= 1'b0;
      tap_q       <= 5'd0;
      tap_fail_q  <= 1'b0;
      cur_start_q <= 5'd0;
      cur_len_q   <= 6'd0;
      run_start_q <= 5'd0;
      run_len_q   <= 6'd0;
      run_edge_q  <= 1'b0;
      rx_rst_q    <= 1'b0;
      conf_dly_q  <= 5'd2;
      conf_edge_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      best_dly_q  <= 5'd2;
      best_edge_q <= 1'b1;
      eye_width_q <= 6'd0;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
      eye_map_q   <= 64'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      tap_q       <= tap_d;
      tap_fail_q  <= tap_fail_d;
      cur_start_q <= cur_start_d;
      cur_len_q   <= cur_len_d;
      run_start_q <= run_start_d;
      run_len_q   <= run_len_d;
      run_edge_q  <= run_edge_d;
      rx_rst_q    <= rx_rst_d;
      conf_dly_q  <= conf_dly_d;
      conf_edge_q <= conf_edge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      best_dly_q  <= best_dly_d;
      best_edge_q <= best_edge_d;
      eye_width_q <= eye_width_d;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
      eye_map_q   <= eye_map_d;
`endif
    end
  end

  assign RX_RST             = rx_rst_q;
  assign CONF_RX_DATA_DLY   = conf_dly_q;
  assign CONF_SAMPLING_EDGE = conf_edge_q;
  assign BUSY               = busy_q;
  assign DONE               = done_q;
  assign FAIL               = fail_q;
  assign BEST_DLY           = best_dly_q;
  assign BEST_EDGE          = best_edge_q;
  assign EYE_WIDTH          = eye_width_q;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
  assign EYE_MAP            = eye_map_q;
`endif

endmodule

// File: tb/tb_tjmono2_rx_eye_scan.sv
// Randomized self-checking bench for tjmono2_rx_eye_scan; the expected eye is derived from the
// per-tap pass mask the bench itself chooses.
module tb_tjmono2_rx_eye_scan;

  localparam int SETTLE = 4;
  localparam int LOCKTO = 16;
  localparam int TESTC  = 32;

  logic        clk = 1'b0;
  logic        bus_rst, start, rx_ready, dec_err;
  logic        rx_rst, conf_edge, dut_busy, dut_done, dut_fail, best_edge;
  logic [4:0]  conf_dly, best_dly;
  logic [5:0]  eye_width;
`ifdef TJMONO2_EYE_SCAN_MAP_EN
  logic [63:0] eye_map;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tjmono2_rx_eye_scan #(
    .SETTLE_CYCLES(SETTLE), .LOCK_TIMEOUT(LOCKTO), .TEST_CYCLES(TESTC), .CNT_W(17)
  ) dut (
    .BUS_CLK(clk), .BUS_RST(bus_rst), .START(start), .RX_READY(rx_ready),
    .DECODER_ERR(dec_err), .RX_RST(rx_rst), .CONF_RX_DATA_DLY(conf_dly),
    .CONF_SAMPLING_EDGE(conf_edge), .BUSY(dut_busy), .DONE(dut_done), .FAIL(dut_fail),
    .BEST_DLY(best_dly), .BEST_EDGE(best_edge), .EYE_WIDTH(eye_width)
`ifdef TJMONO2_EYE_SCAN_MAP_EN
    , .EYE_MAP(eye_map)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Widest run of passing taps per edge; strict '>' keeps the earliest run on ties.
  function automatic void ref_eval(input logic [63:0] m, output int w, output int dly, output int e);
    int len;
    w = 0; dly = 2; e = 1;
    for (int ed = 0; ed < 2; ed++) begin
      for (int s = 0; s < 32; s++) begin
        if (s > 0 && m[ed*32+s-1]) continue;
        len = 0;
        while (s + len < 32 && m[ed*32+s+len]) len++;
        if (len > w) begin
          w = len; dly = s + (len - 1) / 2; e = ed;
        end
      end
    end
  endfunction

  task automatic check_reset_values(input string pfx);
    check_eq({pfx, "_rx_rst"}, rx_rst, 1'b0);
    check_eq({pfx, "_conf_dly"}, conf_dly, 5'd2);
    check_eq({pfx, "_conf_edge"}, conf_edge, 1'b1);
    check_eq({pfx, "_busy"}, dut_busy, 1'b0);
    check_eq({pfx, "_done"}, dut_done, 1'b0);
    check_eq({pfx, "_fail"}, dut_fail, 1'b0);
    check_eq({pfx, "_best_dly"}, best_dly, 5'd2);
    check_eq({pfx, "_best_edge"}, best_edge, 1'b1);
    check_eq({pfx, "_eye_width"}, eye_width, 6'd0);
  endtask

  task automatic run_scan(input logic [63:0] mask, input bit no_lock, input bit drop_mode,
                          input bit abort7, input bit stray_start, input int exp_len);
    int cycles, pulses, step, p, err_p, exp_w, exp_dly, exp_edge;
    logic [5:0] cur;
    bit seen_done;
    ref_eval(mask, exp_w, exp_dly, exp_edge);
    cycles = 0; pulses = 0; step = 0; p = 0; err_p = 6; cur = 6'd0; seen_done = 1'b0;
    rx_ready = !no_lock; dec_err = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_busy", dut_busy, 1'b1);
    check_eq("start_done", dut_done, 1'b0);
    check_eq("start_fail", dut_fail, 1'b0);
    while (cycles < 20000 && !seen_done) begin
      if (rx_rst) begin
        pulses++; p = 0;
        if (step < 64) begin
          check_eq("tap_seq", {conf_edge, conf_dly}, 64'(step));
          cur = 6'(step); step++; err_p = $urandom_range(37, 6);
        end
      end else begin
        p++;
      end
      if (dut_done) begin
        seen_done = 1'b1;
      end else begin
        rx_ready = !no_lock; dec_err = 1'b0; start = 1'b0;
        if (p >= 1 && p <= 4) dec_err = 1'($urandom_range(1, 0));
        if (!mask[cur] && p == err_p) begin
          if (drop_mode && cur[0]) rx_ready = 1'b0;
          else dec_err = 1'b1;
        end
        if (stray_start && cur == 6'd20 && p == 12) start = 1'b1;
        if (abort7 && cur == 6'd7 && p == 10) begin
          bus_rst = 1'b1;
          @(posedge clk); #1;
          bus_rst = 1'b0; dec_err = 1'b0;
          check_reset_values("abort");
          return;
        end
        @(posedge clk); #1;
        cycles++;
      end
    end
    check_eq("scan_finished", seen_done, 1'b1);
    check_eq("done", dut_done, 1'b1);
    check_eq("busy", dut_busy, 1'b0);
    check_eq("fail", dut_fail, exp_w == 0);
    check_eq("best_dly", best_dly, 64'(exp_dly));
    check_eq("best_edge", best_edge, 64'(exp_edge));
    check_eq("eye_width", eye_width, 64'(exp_w));
    check_eq("conf_dly", conf_dly, 64'(exp_dly));
    check_eq("conf_edge", conf_edge, 64'(exp_edge));
    check_eq("rx_rst_pulses", pulses, 64'd65);
    check_eq("taps_applied", step, 64'd64);
    if (exp_len != 0) check_eq("scan_cycles", cycles, 64'(exp_len));
`ifdef TJMONO2_EYE_SCAN_MAP_EN
    check_eq("eye_map", eye_map, mask);
`endif
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("hold_rx_rst", rx_rst, 1'b0);
    check_eq("hold_done", dut_done, 1'b1);
    check_eq("hold_best_dly", best_dly, 64'(exp_dly));
    check_eq("hold_width", eye_width, 64'(exp_w));
  endtask

  initial begin
    logic [63:0] m;
    int s0, l0;
    bus_rst = 1'b1; start = 1'b0; rx_ready = 1'b0; dec_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    bus_rst = 1'b0;
    @(posedge clk); #1;

    run_scan(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 64 * (3 + SETTLE + TESTC) + 1);
    run_scan(64'h0000_0000_000F_FC00, 1'b0, 1'b0, 1'b0, 1'b0, 64 * (3 + SETTLE + TESTC) + 1);
    run_scan(64'h0000_0F00_0000_0078, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_scan(64'h0000_1F00_0000_0078, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_scan(64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64 * (2 + SETTLE + LOCKTO) + 1);
    run_scan(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    for (int r = 0; r < 6; r++) begin
      m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      for (int ed = 0; ed < 2; ed++) begin
        s0 = $urandom_range(31, 0);
        l0 = $urandom_range(32, 0);
        for (int t = 0; t < l0 && s0 + t < 32; t++) m[ed*32+s0+t] = 1'b1;
      end
      run_scan(m, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
